// File: rtl/store_pkg.sv
// ---------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store byte-lane unit:
//   - store_mode_e : encoding of the req_mode port (6 and 7 are illegal)
//   - state_e      : request FSM states
//   - size_of()    : access size in bytes for a mode (0 for unsized modes)
// ---------------------------------------------------------------------------
package store_pkg;

  typedef enum logic [2:0] {
    MODE_FULL  = 3'd0,
    MODE_HALF  = 3'd1,
    MODE_BYTE  = 3'd2,
    MODE_LEFT  = 3'd3,
    MODE_RIGHT = 3'd4,
    MODE_WORD  = 3'd5
  } store_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } state_e;

  // LEFT/RIGHT and illegal encodings have no fixed size and return 0.
  function automatic int size_of(input store_mode_e mode, input int nb);
    case (mode)
      MODE_FULL: return nb;
      MODE_WORD: return 4;
      MODE_HALF: return 2;
      MODE_BYTE: return 1;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// ---------------------------------------------------------------------------
// store_lane_align
// Combinational lane steering for one store request. Produces byte enables
// and lane-aligned data for the first beat and for a possible second beat
// (the part of a misaligned store that spills into the next bus word).
//
// Ports:
//   mode       in   3       store mode (store_mode_e encoding)
//   off        in   OFF_W   byte offset within the bus word
//   wdata      in   DATA_W  register value, right-justified
//   be0/be1    out  NB      byte enables for beat 0 / beat 1
//   wdata0/1   out  DATA_W  lane data for beat 0 / beat 1, disabled lanes 0
//   split      out  1       sized store crosses the bus word boundary
//   misaligned out  1       sized store whose offset is not size-aligned
//   illegal    out  1       mode 6 or 7
// ---------------------------------------------------------------------------
module store_lane_align
  import store_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [2:0]        mode,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  output logic [NB-1:0]     be0,
  output logic [NB-1:0]     be1,
  output logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] wdata1,
  output logic              split,
  output logic              misaligned,
  output logic              illegal
);

  int                  size;
  int                  off_i;
  logic [2*NB-1:0]     wide_be;
  logic [2*DATA_W-1:0] wide_d;
  logic [DATA_W-1:0]   raw0;
  logic [DATA_W-1:0]   raw1;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    be0        = '0;
    be1        = '0;
    raw0       = '0;
    raw1       = '0;
    wide_be    = '0;
    wide_d     = '0;
    split      = 1'b0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    off_i      = int'(off);
    size       = size_of(store_mode_e'(mode), NB);

    case (store_mode_e'(mode))
      MODE_FULL, MODE_WORD, MODE_HALF, MODE_BYTE: begin
        // Shift a double-width window: the low half is beat 0, whatever
        // spills into the high half is beat 1 at the next bus word.
        wide_be      = ~({(2*NB){1'b1}} << size) << off_i;
        wide_d       = {{DATA_W{1'b0}}, wdata} << (8 * off_i);
        {be1, be0}   = wide_be;
        {raw1, raw0} = wide_d;
        misaligned   = (off_i % size) != 0;
        split        = (off_i + size) > NB;
      end
      MODE_LEFT: begin
        be0  = ~({NB{1'b1}} << (off_i + 1));
        raw0 = wdata >> (8 * (NB - 1 - off_i));
      end
      MODE_RIGHT: begin
        be0  = {NB{1'b1}} << off_i;
        raw0 = wdata << (8 * off_i);
      end
      default: illegal = 1'b1;
    endcase
  end

  // Zero every lane whose enable is clear (drops register bits above size).
  always_comb begin
    wdata0 = '0;
    wdata1 = '0;
    for (int i = 0; i < NB; i++) begin
      wdata0[8*i +: 8] = be0[i] ? raw0[8*i +: 8] : 8'h00;
      wdata1[8*i +: 8] = be1[i] ? raw1[8*i +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/store_be_unit.sv
// ---------------------------------------------------------------------------
// store_be_unit
// Store-side byte-lane unit between MEM and the data-memory write port.
// Accepts one store per req handshake, issues one or two registered write
// beats on a valid/ready bus, then pulses done (with err if rejected).
//
// Build option: define STORE_SPLIT_EN to split misaligned stores that cross
// a bus word into two beats. Without it every misaligned sized store is
// rejected with err and no beat.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req_valid/req_ready    request handshake
//   req_mode, req_addr,
//   req_wdata              store mode, byte address, right-justified data
//   bus_valid/bus_ready    write beat handshake
//   bus_addr, bus_be,
//   bus_wdata              word-aligned address, byte enables, lane data
//   done, err              completion pulse, rejection flag with done
// ---------------------------------------------------------------------------
module store_be_unit
  import store_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [NB-1:0]     bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              done,
  output logic              err
);

`ifdef STORE_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e            state;
  state_e            state_nxt;

  logic [NB-1:0]     be0;
  logic [NB-1:0]     be1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              split;
  logic              misaligned;
  logic              illegal;

  logic              reject;
  logic              split_d;
  logic              accept;
  logic              beat0_done;

  logic              err_q;
  logic              split_q;
  logic [NB-1:0]     be1_q;
  logic [DATA_W-1:0] wdata1_q;

  store_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .mode       (req_mode),
    .off        (req_addr[OFF_W-1:0]),
    .wdata      (req_wdata),
    .be0        (be0),
    .be1        (be1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .split      (split),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  // Without splitting, a misaligned store is rejected; with it, only an
  // illegal mode is, and a crossing store takes the second beat.
  assign reject     = illegal | (misaligned & ~SPLIT_EN);
  assign split_d    = split & SPLIT_EN;
  assign accept     = (state == ST_IDLE) && req_valid;
  assign beat0_done = (state == ST_BEAT0) && bus_ready;

  // Control outputs decode directly from the state register.
  assign req_ready = (state == ST_IDLE);
  assign bus_valid = (state == ST_BEAT0) || (state == ST_BEAT1);
  assign done      = (state == ST_RESP);
  assign err       = (state == ST_RESP) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = reject ? ST_RESP : ST_BEAT0;
      ST_BEAT0: if (bus_ready) state_nxt = split_q ? ST_BEAT1 : ST_RESP;
      ST_BEAT1: if (bus_ready) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Beat registers: loaded at acceptance, swapped to the second-beat values
  // when beat 0 completes, otherwise held (stable while stalled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      split_q   <= 1'b0;
      be1_q     <= '0;
      wdata1_q  <= '0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else if (accept) begin
      err_q <= reject;
      if (!reject) begin
        split_q   <= split_d;
        be1_q     <= be1;
        wdata1_q  <= wdata1;
        bus_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        bus_be    <= be0;
        bus_wdata <= wdata0;
      end
    end else if (beat0_done && split_q) begin
      bus_addr  <= bus_addr + ADDR_W'(NB);
      bus_be    <= be1_q;
      bus_wdata <= wdata1_q;
    end
  end

endmodule

// File: tb/tb_store_be_unit.sv
// ---------------------------------------------------------------------------
// tb_store_be_unit
// Directed table of store requests with hand-computed beats, plus sequences
// for bus stalls and reset in the middle of a request. Expectations follow
// the STORE_SPLIT_EN setting of the build. DATA_W = 32, ADDR_W = 32.
// ---------------------------------------------------------------------------
module tb_store_be_unit;

  localparam logic [2:0] FULL  = 3'd0;
  localparam logic [2:0] HALF  = 3'd1;
  localparam logic [2:0] BYTE  = 3'd2;
  localparam logic [2:0] LEFT  = 3'd3;
  localparam logic [2:0] RIGHT = 3'd4;
  localparam logic [2:0] WORD  = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        done;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  store_be_unit #(
    .DATA_W (32),
    .ADDR_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          beats;   // 0 = rejected
    logic [31:0] a0;
    logic [3:0]  b0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  b1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [2:0] mode, logic [31:0] addr,
                              logic [31:0] wdata, int beats,
                              logic [31:0] a0, logic [3:0] b0, logic [31:0] d0,
                              logic [31:0] a1, logic [3:0] b1, logic [31:0] d1);
    vec_t v;
    v.name = name; v.mode = mode; v.addr = addr; v.wdata = wdata;
    v.beats = beats;
    v.a0 = a0; v.b0 = b0; v.d0 = d0;
    v.a1 = a1; v.b1 = b1; v.d1 = d1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Called at a negedge with the unit idle; returns at a negedge, idle again.
  task automatic run_vec(input vec_t v);
    check({v.name, ".ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_mode  = v.mode;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    bus_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.beats == 0) begin
      check({v.name, ".done"},  64'(done),      64'd1);
      check({v.name, ".err"},   64'(err),       64'd1);
      check({v.name, ".valid"}, 64'(bus_valid), 64'd0);
    end else begin
      check({v.name, ".valid0"}, 64'(bus_valid), 64'd1);
      check({v.name, ".done0"},  64'(done),      64'd0);
      check({v.name, ".addr0"},  64'(bus_addr),  64'(v.a0));
      check({v.name, ".be0"},    64'(bus_be),    64'(v.b0));
      check({v.name, ".data0"},  64'(bus_wdata), 64'(v.d0));
      @(negedge clk);
      if (v.beats == 2) begin
        check({v.name, ".valid1"}, 64'(bus_valid), 64'd1);
        check({v.name, ".addr1"},  64'(bus_addr),  64'(v.a1));
        check({v.name, ".be1"},    64'(bus_be),    64'(v.b1));
        check({v.name, ".data1"},  64'(bus_wdata), 64'(v.d1));
        @(negedge clk);
      end
      check({v.name, ".done"},    64'(done),      64'd1);
      check({v.name, ".err"},     64'(err),       64'd0);
      check({v.name, ".validR"},  64'(bus_valid), 64'd0);
    end
    @(negedge clk);
    check({v.name, ".done_off"}, 64'(done),      64'd0);
    check({v.name, ".idle"},     64'(req_ready), 64'd1);
    check({v.name, ".idle_bv"},  64'(bus_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_data;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_mode  = '0;
    req_addr  = '0;
    req_wdata = '0;
    bus_ready = 1'b1;

    // ---- reset state ----
    #12;
    check("rst.ready", 64'(req_ready), 64'd1);
    check("rst.valid", 64'(bus_valid), 64'd0);
    check("rst.addr",  64'(bus_addr),  64'd0);
    check("rst.be",    64'(bus_be),    64'd0);
    check("rst.data",  64'(bus_wdata), 64'd0);
    check("rst.done",  64'(done),      64'd0);
    check("rst.err",   64'(err),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- vector table ----
    vecs.push_back(mk("byte_1003", BYTE, 32'h1003, 32'h0000_00AB, 1,
                      32'h1000, 4'b1000, 32'hAB00_0000, '0, '0, '0));
    vecs.push_back(mk("left_2001", LEFT, 32'h2001, 32'h1122_3344, 1,
                      32'h2000, 4'b0011, 32'h0000_1122, '0, '0, '0));
    vecs.push_back(mk("right_2001", RIGHT, 32'h2001, 32'h1122_3344, 1,
                      32'h2000, 4'b1110, 32'h2233_4400, '0, '0, '0));
    vecs.push_back(mk("word_4000", WORD, 32'h4000, 32'hDEAD_BEEF, 1,
                      32'h4000, 4'b1111, 32'hDEAD_BEEF, '0, '0, '0));
    vecs.push_back(mk("full_4004", FULL, 32'h4004, 32'h0102_0304, 1,
                      32'h4004, 4'b1111, 32'h0102_0304, '0, '0, '0));
    vecs.push_back(mk("half_4002", HALF, 32'h4002, 32'h1234_ABCD, 1,
                      32'h4000, 4'b1100, 32'hABCD_0000, '0, '0, '0));
    vecs.push_back(mk("byte_4000", BYTE, 32'h4000, 32'hFFFF_FF5A, 1,
                      32'h4000, 4'b0001, 32'h0000_005A, '0, '0, '0));
    vecs.push_back(mk("left_5003", LEFT, 32'h5003, 32'h1122_3344, 1,
                      32'h5000, 4'b1111, 32'h1122_3344, '0, '0, '0));
    vecs.push_back(mk("left_5000", LEFT, 32'h5000, 32'h1122_3344, 1,
                      32'h5000, 4'b0001, 32'h0000_0011, '0, '0, '0));
    vecs.push_back(mk("right_5003", RIGHT, 32'h5003, 32'h1122_3344, 1,
                      32'h5000, 4'b1000, 32'h4400_0000, '0, '0, '0));
    vecs.push_back(mk("right_5000", RIGHT, 32'h5000, 32'h1122_3344, 1,
                      32'h5000, 4'b1111, 32'h1122_3344, '0, '0, '0));
    vecs.push_back(mk("mode6", 3'd6, 32'h6000, 32'h1111_1111, 0,
                      '0, '0, '0, '0, '0, '0));
    vecs.push_back(mk("mode7", 3'd7, 32'h6004, 32'h2222_2222, 0,
                      '0, '0, '0, '0, '0, '0));
`ifdef STORE_SPLIT_EN
    vecs.push_back(mk("full_3002", FULL, 32'h3002, 32'hAABB_CCDD, 2,
                      32'h3000, 4'b1100, 32'hCCDD_0000,
                      32'h3004, 4'b0011, 32'h0000_AABB));
    vecs.push_back(mk("half_3001", HALF, 32'h3001, 32'h0000_BEEF, 1,
                      32'h3000, 4'b0110, 32'h00BE_EF00, '0, '0, '0));
    vecs.push_back(mk("word_6003", WORD, 32'h6003, 32'h0102_0304, 2,
                      32'h6000, 4'b1000, 32'h0400_0000,
                      32'h6004, 4'b0111, 32'h0001_0203));
    vecs.push_back(mk("half_6003", HALF, 32'h6003, 32'h0000_CAFE, 2,
                      32'h6000, 4'b1000, 32'hFE00_0000,
                      32'h6004, 4'b0001, 32'h0000_00CA));
    vecs.push_back(mk("full_7001", FULL, 32'h7001, 32'h1122_3344, 2,
                      32'h7000, 4'b1110, 32'h2233_4400,
                      32'h7004, 4'b0001, 32'h0000_0011));
`else
    vecs.push_back(mk("full_3002", FULL, 32'h3002, 32'hAABB_CCDD, 0,
                      '0, '0, '0, '0, '0, '0));
    vecs.push_back(mk("half_3001", HALF, 32'h3001, 32'h0000_BEEF, 0,
                      '0, '0, '0, '0, '0, '0));
    vecs.push_back(mk("word_6003", WORD, 32'h6003, 32'h0102_0304, 0,
                      '0, '0, '0, '0, '0, '0));
    vecs.push_back(mk("half_6003", HALF, 32'h6003, 32'h0000_CAFE, 0,
                      '0, '0, '0, '0, '0, '0));
`endif

    foreach (vecs[i]) run_vec(vecs[i]);

    // ---- stall in BEAT0 with a concurrent request that must be ignored ----
    req_valid = 1'b1;
    req_mode  = FULL;
    req_addr  = 32'h3000;
    req_wdata = 32'h5566_7788;
    bus_ready = 1'b0;
    @(negedge clk);
    s_addr = 32'h3000;
    s_be   = 4'b1111;
    s_data = 32'h5566_7788;
    req_mode  = BYTE;
    req_addr  = 32'h9001;
    req_wdata = 32'h0000_00EE;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d.valid", k), 64'(bus_valid), 64'd1);
      check($sformatf("stall%0d.ready", k), 64'(req_ready), 64'd0);
      check($sformatf("stall%0d.addr", k),  64'(bus_addr),  64'(s_addr));
      check($sformatf("stall%0d.be", k),    64'(bus_be),    64'(s_be));
      check($sformatf("stall%0d.data", k),  64'(bus_wdata), 64'(s_data));
      check($sformatf("stall%0d.done", k),  64'(done),      64'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    bus_ready = 1'b1;
    check("stall.release_valid", 64'(bus_valid), 64'd1);
    check("stall.release_data",  64'(bus_wdata), 64'(s_data));
    @(negedge clk);
    check("stall.done", 64'(done), 64'd1);
    check("stall.err",  64'(err),  64'd0);
    @(negedge clk);
    check("stall.idle",  64'(req_ready), 64'd1);
    check("stall.no_q",  64'(bus_valid), 64'd0);
    @(negedge clk);
    check("stall.no_q2", 64'(bus_valid), 64'd0);

    // ---- asynchronous reset in the middle of a request ----
    req_valid = 1'b1;
`ifdef STORE_SPLIT_EN
    req_mode  = FULL;
    req_addr  = 32'h3002;
    req_wdata = 32'hAABB_CCDD;
    bus_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid.in_beat1", 64'(bus_be), 64'(4'b0011));
`else
    req_mode  = FULL;
    req_addr  = 32'h3000;
    req_wdata = 32'hAABB_CCDD;
    bus_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid.in_beat0", 64'(bus_be), 64'(4'b1111));
`endif
    check("rstmid.valid_pre", 64'(bus_valid), 64'd1);
    bus_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.valid", 64'(bus_valid), 64'd0);
    check("rstmid.ready", 64'(req_ready), 64'd1);
    check("rstmid.be",    64'(bus_be),    64'd0);
    check("rstmid.data",  64'(bus_wdata), 64'd0);
    check("rstmid.done",  64'(done),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid.done_hold", 64'(done), 64'd0);
    @(negedge clk);
    check("rstmid.done_after", 64'(done),      64'd0);
    check("rstmid.valid_after", 64'(bus_valid), 64'd0);
    run_vec(mk("byte_post_rst", BYTE, 32'h1003, 32'h0000_00AB, 1,
               32'h1000, 4'b1000, 32'hAB00_0000, '0, '0, '0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
